ex_mem_pipe_stage: RTL and testbench

//  Parametrised EX/MEM pipeline stage with a valid/ready handshake, 2-entry skid buffer and synchronous flush.

---
 rtl/ex_mem_pipe_stage.sv | 128 ++++++++++++
 tb/tb_ex_mem_pipe_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_pipe_stage.sv
// EX/MEM pipeline register with valid/ready handshake, 2-entry skid buffer and synchronous flush.
// Optional EXMEM_STATS_EN adds saturating stall/flush counters (StallCnt, FlushCnt).
module ex_mem_pipe_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 5
`ifdef EXMEM_STATS_EN
    ,
    parameter int CNT_W      = 16
`endif
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Flush,
    input  logic                  In_Valid,
    output logic                  In_Ready,
    input  logic [CTRL_W-1:0]     Ctrl_In,
    input  logic [DATA_W-1:0]     ALUResult_In,
    input  logic [DATA_W-1:0]     RegisterRead2_In,
    input  logic                  ALUZero_In,
    input  logic [REG_ADDR_W-1:0] RegDst_In,
    output logic                  Out_Valid,
    input  logic                  Out_Ready,
    output logic [CTRL_W-1:0]     Ctrl_Out,
    output logic [DATA_W-1:0]     ALUResult_Out,
    output logic [DATA_W-1:0]     RegisterRead2_Out,
    output logic                  ALUZero_Out,
    output logic [REG_ADDR_W-1:0] RegDst_Out
`ifdef EXMEM_STATS_EN
    ,
    output logic [CNT_W-1:0]      StallCnt,
    output logic [CNT_W-1:0]      FlushCnt
`endif
);

    typedef struct packed {
        logic [CTRL_W-1:0]     ctrl;
        logic [DATA_W-1:0]     aluResult;
        logic [DATA_W-1:0]     regRead2;
        logic                  aluZero;
        logic [REG_ADDR_W-1:0] regDst;
    } EntryT;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} StateT;

    StateT state, nextState;
    EntryT mainQ, skidQ, inEntry;
    logic  inReadyQ, inFire, outFire, outValid;

    assign inEntry  = {Ctrl_In, ALUResult_In, RegisterRead2_In, ALUZero_In, RegDst_In};
    assign outValid = (state != EMPTY);
    assign inFire   = In_Valid & inReadyQ;
    assign outFire  = outValid & Out_Ready;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        nextState = state;
        if (Flush) begin
            nextState = EMPTY;
        end else begin
            case (state)
                EMPTY:   if (inFire) nextState = ONE;
                ONE: begin
                    if (inFire && !outFire)      nextState = TWO;
                    else if (!inFire && outFire) nextState = EMPTY;
                end
                TWO:     if (outFire) nextState = ONE;
                default: nextState = EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= EMPTY;
            mainQ    <= '0;
            skidQ    <= '0;
            inReadyQ <= 1'b1;
        end else begin
            state <= nextState;
            // Ready is a register of next-state, keeping Out_Ready off any combinational path to In_Ready.
            inReadyQ <= (nextState != TWO);
            if (Flush) begin
                mainQ.ctrl <= '0;
                skidQ.ctrl <= '0;
            end else begin
                case (state)
                    EMPTY: if (inFire) mainQ <= inEntry;
                    ONE: begin
                        if (inFire && outFire) mainQ <= inEntry;
                        else if (inFire)       skidQ <= inEntry;
                    end
                    TWO:     if (outFire) mainQ <= skidQ;
                    default: ;
                endcase
            end
        end
    end

    assign In_Ready          = inReadyQ;
    assign Out_Valid         = outValid;
    assign Ctrl_Out          = mainQ.ctrl & {CTRL_W{outValid}};
    assign ALUResult_Out     = mainQ.aluResult;
    assign RegisterRead2_Out = mainQ.regRead2;
    assign ALUZero_Out       = mainQ.aluZero;
    assign RegDst_Out        = mainQ.regDst;

`ifdef EXMEM_STATS_EN
    logic [CNT_W-1:0] stallCnt, flushCnt;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (outValid && !Out_Ready && stallCnt != '1)
                stallCnt <= stallCnt + CNT_W'(1);
            if (Flush && (outValid || In_Valid) && flushCnt != '1)
                flushCnt <= flushCnt + CNT_W'(1);
        end
    end

    assign StallCnt = stallCnt;
    assign FlushCnt = flushCnt;
`endif

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Self-checking bench for ex_mem_pipe_stage: queue-based reference model plus scripted literal checks.
module tb_ex_mem_pipe_stage;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 5;
`ifdef EXMEM_STATS_EN
    localparam int CNTW   = 4;
    localparam int SATMAX = (1 << CNTW) - 1;
`endif

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] alu;
        logic [DW-1:0] rd2;
        logic          zero;
        logic [AW-1:0] dst;
    } ent_t;

    logic          Clk, Rst_n, Flush, In_Valid, In_Ready, ALUZero_In, Out_Valid, Out_Ready, ALUZero_Out;
    logic [CW-1:0] Ctrl_In, Ctrl_Out;
    logic [DW-1:0] ALUResult_In, RegisterRead2_In, ALUResult_Out, RegisterRead2_Out;
    logic [AW-1:0] RegDst_In, RegDst_Out;
`ifdef EXMEM_STATS_EN
    logic [CNTW-1:0] StallCnt, FlushCnt;
`endif

    ex_mem_pipe_stage #(
        .DATA_W(DW), .REG_ADDR_W(AW), .CTRL_W(CW)
`ifdef EXMEM_STATS_EN
        , .CNT_W(CNTW)
`endif
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush),
        .In_Valid(In_Valid), .In_Ready(In_Ready),
        .Ctrl_In(Ctrl_In), .ALUResult_In(ALUResult_In), .RegisterRead2_In(RegisterRead2_In),
        .ALUZero_In(ALUZero_In), .RegDst_In(RegDst_In),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .Ctrl_Out(Ctrl_Out), .ALUResult_Out(ALUResult_Out), .RegisterRead2_Out(RegisterRead2_Out),
        .ALUZero_Out(ALUZero_Out), .RegDst_Out(RegDst_Out)
`ifdef EXMEM_STATS_EN
        , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most two entries, in-ready tracked as "fewer than two held".
    ent_t q[$];
    bit   mReady;
    bit   mInFire, mOutFire;
    bit   cmpEn = 1'b0;
`ifdef EXMEM_STATS_EN
    int mStall, mFlush;
`endif

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            q.delete();
            mReady = 1'b1;
`ifdef EXMEM_STATS_EN
            mStall = 0;
            mFlush = 0;
`endif
        end else begin
`ifdef EXMEM_STATS_EN
            if (q.size() > 0 && !Out_Ready && mStall < SATMAX) mStall++;
            if (Flush && (q.size() > 0 || In_Valid) && mFlush < SATMAX) mFlush++;
`endif
            if (Flush) begin
                q.delete();
                mReady = 1'b1;
            end else begin
                mInFire  = In_Valid && mReady;
                mOutFire = (q.size() > 0) && Out_Ready;
                if (mOutFire) void'(q.pop_front());
                if (mInFire)  q.push_back({Ctrl_In, ALUResult_In, RegisterRead2_In, ALUZero_In, RegDst_In});
                mReady = (q.size() < 2);
            end
        end
    end

    always @(negedge Clk) begin
        if (cmpEn) begin
            check("out_valid", 128'(Out_Valid), 128'(q.size() > 0));
            check("in_ready", 128'(In_Ready), 128'(mReady));
            if (q.size() > 0) begin
                check("ctrl_out", 128'(Ctrl_Out), 128'(q[0].ctrl));
                check("payload", 128'({ALUResult_Out, RegisterRead2_Out, ALUZero_Out, RegDst_Out}),
                      128'({q[0].alu, q[0].rd2, q[0].zero, q[0].dst}));
            end else begin
                check("ctrl_bubble", 128'(Ctrl_Out), 128'(0));
            end
`ifdef EXMEM_STATS_EN
            check("stall_cnt", 128'(StallCnt), 128'(mStall));
            check("flush_cnt", 128'(FlushCnt), 128'(mFlush));
`endif
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] a);
        In_Valid         = v;
        Ctrl_In          = c;
        ALUResult_In     = a;
        RegisterRead2_In = $urandom;
        ALUZero_In       = 1'($urandom);
        RegDst_In        = AW'($urandom);
    endtask

    initial begin
        Rst_n = 1'b0; Flush = 1'b0; Out_Ready = 1'b0;
        drive(1'b0, '0, '0);
        #12;
        check("rst_out_valid", 128'(Out_Valid), 128'(0));
        check("rst_in_ready", 128'(In_Ready), 128'(1));
        check("rst_ctrl", 128'(Ctrl_Out), 128'(0));
        check("rst_alu", 128'(ALUResult_Out), 128'(0));
        Rst_n = 1'b1;
        cmpEn = 1'b1;
        step();

`ifdef EXMEM_STATS_EN
        Out_Ready = 1'b0;
        drive(1'b1, 5'b00011, 32'h77);
        step();
        drive(1'b0, '0, '0);
        repeat (10) step();
        check("stall_10", 128'(StallCnt), 128'(10));
        repeat (10) step();
        check("stall_sat", 128'(StallCnt), 128'(15));
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        check("flush_cnt_1", 128'(FlushCnt), 128'(1));
`endif

        // Streaming at full throughput
        Out_Ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'b01000, DW'(i));
            step();
            check("stream_alu", 128'(ALUResult_Out), 128'(i));
            check("stream_ready", 128'(In_Ready), 128'(1));
        end
        drive(1'b0, '0, '0);
        step();
        check("stream_drained", 128'(Out_Valid), 128'(0));

        // Stall into TWO, then drain in order
        Out_Ready = 1'b0;
        drive(1'b1, 5'b00001, 32'h10);
        step();
        drive(1'b1, 5'b00010, 32'h20);
        step();
        drive(1'b0, '0, '0);
        check("stall_ready", 128'(In_Ready), 128'(0));
        check("stall_head", 128'(ALUResult_Out), 128'(32'h10));
        step();
        check("stall_hold", 128'(ALUResult_Out), 128'(32'h10));
        Out_Ready = 1'b1;
        step();
        check("drain_second", 128'(ALUResult_Out), 128'(32'h20));
        check("drain_ready", 128'(In_Ready), 128'(1));
        step();
        check("drain_empty", 128'(Out_Valid), 128'(0));

        // Flush while full, with an entry offered
        Out_Ready = 1'b0;
        drive(1'b1, 5'b00100, 32'h30);
        step();
        drive(1'b1, 5'b00100, 32'h40);
        step();
        drive(1'b1, 5'b01001, 32'hDEAD);
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        drive(1'b0, '0, '0);
        check("flush_valid", 128'(Out_Valid), 128'(0));
        check("flush_ctrl", 128'(Ctrl_Out), 128'(0));
        check("flush_ready", 128'(In_Ready), 128'(1));
        step();
        check("flush_no_ghost", 128'(Out_Valid), 128'(0));
        Out_Ready = 1'b1;
        drive(1'b1, 5'b00110, 32'h50);
        step();
        check("post_flush_alu", 128'(ALUResult_Out), 128'(32'h50));
        check("post_flush_ctrl", 128'(Ctrl_Out), 128'(5'b00110));

        // Bubbles carry no control
        drive(1'b0, 5'b11111, 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bubble_ctrl", 128'(Ctrl_Out), 128'(0));
            check("bubble_valid", 128'(Out_Valid), 128'(0));
        end

        // Async reset while holding two entries
        Out_Ready = 1'b0;
        drive(1'b1, 5'b10101, 32'h60);
        step();
        drive(1'b1, 5'b10101, 32'h70);
        step();
        drive(1'b0, '0, '0);
        check("pre_rst_full", 128'(In_Ready), 128'(0));
        #2;
        Rst_n = 1'b0;
        #1;
        check("async_valid", 128'(Out_Valid), 128'(0));
        check("async_ctrl", 128'(Ctrl_Out), 128'(0));
        check("async_ready", 128'(In_Ready), 128'(1));
        step();
        Rst_n = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 9) < 7), CW'($urandom), $urandom);
            Out_Ready = ($urandom_range(0, 9) < 6);
            Flush     = ($urandom_range(0, 15) == 0);
            step();
        end
        Flush = 1'b0;
        Out_Ready = 1'b1;
        drive(1'b0, '0, '0);
        repeat (4) step();
        check("final_empty", 128'(Out_Valid), 128'(0));

        cmpEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
